uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Transmit controller for the UART TX path. It accepts a parallel word from the upstream host, then drives the serial line TX_OUT with one bit per CLK: start bit, WIDTH data bits LSB-first, an optional parity bit, and a stop bit. It sits directly downstream of the TX parity calculator and consumes that block's registered parity_bit. Both blocks share P_DATA, Data_Valid and the parity-enable control.

## Interface
- WIDTH, default 8: data word width in bits; must be ≥ 2.
- CLK  input  1  bit-rate clock; one serial bit per CLK cycle.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  WIDTH  parallel word; sampled only on the accepting edge.
- Data_Valid  input  1  one-cycle request to transmit P_DATA.
- PAR_EN  input  1  parity enable; sampled on the accepting edge.
- parity_bit  input  1  registered parity from the parity calculator; valid one CLK after its Data_Valid edge.
- TX_OUT  output  1  serial line, registered; idle level 1.
- Busy  output  1  registered; high while a frame is on the line.

## Operation
- Reset values: TX_OUT=1, Busy=0, state=IDLE, bit counter=0, shift register=0, latched PAR_EN=0.
- State meaning: the state names the bit currently driven on TX_OUT.
- States:
  - IDLE: TX_OUT=1, Busy=0.
  - START: TX_OUT=0.
  - DATA: TX_OUT=shift[0].
  - PARITY: TX_OUT=latched parity.
  - STOP: TX_OUT=1, Busy still 1.
- Accept rule: Data_Valid=1 is accepted only in IDLE or STOP. On the accepting edge:
  - P_DATA is loaded into the shift register and PAR_EN is latched.
  - The counter is cleared and the next state is START.
- Transitions:
  - IDLE→START on accept.
  - START→DATA always.
  - DATA stays in DATA; the shift register shifts right each edge and the counter increments. DATA exits after WIDTH cycles (counter reaches WIDTH-1): to PARITY if the latched PAR_EN=1, else to STOP.
  - PARITY→STOP always.
  - STOP→START on accept (back-to-back frames), else STOP→IDLE.
- Parity capture: parity_bit is captured into a holding register on the edge entering DATA. It is held unchanged until the frame ends.
- Data_Valid in START, DATA or PARITY is a protocol violation. This block ignores it; no state change and the frame continues unaltered. Upstream must not pulse Data_Valid while Busy=1 and the state is not STOP, because the parity calculator would re-latch and the next frame's parity would be wrong.
- PAR_EN changes mid-frame have no effect; only the latched value is used.
- Reset asserted mid-frame: all registers go immediately (asynchronously) to reset values and TX_OUT returns to 1. There is no partial stop bit.

## Timing
- Accept at edge k: TX_OUT=0 and Busy=1 from edge k.
- Data bit i is driven from edge k+1+i.
- Parity bit, if enabled, is driven from edge k+WIDTH+1.
- Stop bit is driven from edge k+WIDTH+1+P, where P is 1 when parity is enabled and 0 otherwise.
- Frame length: WIDTH+2+P cycles. For WIDTH=8: 10 cycles without parity, 11 with.
- Return to idle: with no new accept, Busy=0 and TX_OUT=1 from edge k+WIDTH+2+P.
- Back-to-back: Data_Valid in the stop cycle starts the next START at edge k+WIDTH+2+P. Throughput is one word per frame length with no idle gap.
- Parity timing: parity_bit is valid at edge k+1 and captured at edge k+1, which is the START→DATA edge.
- Counter: width $clog2(WIDTH). Its terminal value is WIDTH-1 and it never wraps within a frame.

## Structure
- Shared package uart_pkg holds:
  - The state enum (IDLE, START, DATA, PARITY, STOP).
  - Constants UART_IDLE_LVL=1, UART_START_LVL=0, UART_STOP_LVL=1.
- Sub-module uart_tx_serializer contains the shift register and bit counter.
  - Inputs: load, shift_en, P_DATA.
  - Outputs: ser_bit, ser_done.
- uart_tx_ctrl holds the FSM, the parity holding register and the registered TX_OUT/Busy mux.

## Test plan
- WIDTH=8, PAR_EN=0, P_DATA=0xA5 accepted at edge k → TX_OUT = 0,1,0,1,0,0,1,0,1,1 over edges k..k+9. Busy=1 for 10 cycles, then TX_OUT=1 and Busy=0.
- PAR_EN=1, even parity, P_DATA=0x37 (five ones) with parity_bit=1 from the calculator → parity slot at k+9 drives 1, stop at k+10, frame length 11.
- Back-to-back: 0x00 then 0xFF, with Data_Valid on the stop cycle of frame 1 → frame 2 START immediately follows the stop bit with no idle cycle, and Busy stays 1 throughout.
- Data_Valid pulsed during DATA of 0x5A → ignored; the frame completes as 0x5A with unchanged length.
- RST low at edge k+4 of a frame → TX_OUT=1 and Busy=0 immediately. After release, a fresh accept of 0x81 transmits correctly.
- PAR_EN toggled 1→0 mid-frame after accepting with PAR_EN=1 → the parity bit is still sent and the frame is 11 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding and serial line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for the UART TX path.
// ser_bit_o is the data bit that will be on the line after the coming edge.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] p_data_i,
  output logic             ser_bit_o,
  output logic             ser_done_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = p_data_i;
      cnt_d   = '0;
    end else if (shift_en_i) begin
      shift_d = {1'b0, shift_q[WIDTH-1:1]};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entering DATA nothing has shifted yet, so bit 0 is next; inside DATA the
  // register shifts on the same edge, so the following bit is next.
  assign ser_bit_o  = shift_en_i ? shift_q[1] : shift_q[0];
  assign ser_done_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel word as start, data (LSB first),
// optional parity and stop bits, one bit per CLK, with registered outputs.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             parity_bit,
  output logic             TX_OUT,
  output logic             Busy
);

  uart_state_e state_q;
  logic        tx_q, busy_q, par_en_q, par_q;
  logic        accept, shift_en, ser_bit, ser_done;

  // Requests outside IDLE/STOP are dropped; the frame on the line is untouched.
  assign accept   = Data_Valid && (state_q == IDLE || state_q == STOP);
  assign shift_en = (state_q == DATA) && !ser_done;

  uart_tx_serializer #(.WIDTH(WIDTH)) u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load_i    (accept),
    .shift_en_i(shift_en),
    .p_data_i  (P_DATA),
    .ser_bit_o (ser_bit),
    .ser_done_o(ser_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      tx_q     <= UART_IDLE_LVL;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, STOP: begin
          if (accept) begin
            state_q  <= START;
            tx_q     <= UART_START_LVL;
            busy_q   <= 1'b1;
            par_en_q <= PAR_EN;
          end else begin
            state_q <= IDLE;
            tx_q    <= UART_IDLE_LVL;
            busy_q  <= 1'b0;
          end
        end
        START: begin
          state_q <= DATA;
          tx_q    <= ser_bit;
          // Upstream parity register becomes valid one edge after the accept.
          par_q   <= parity_bit;
        end
        DATA: begin
          if (!ser_done) begin
            tx_q <= ser_bit;
          end else if (par_en_q) begin
            state_q <= PARITY;
            tx_q    <= par_q;
          end else begin
            state_q <= STOP;
            tx_q    <= UART_STOP_LVL;
          end
        end
        PARITY: begin
          state_q <= STOP;
          tx_q    <= UART_STOP_LVL;
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= UART_IDLE_LVL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed frames plus random traffic checked per cycle
// against a frame-queue model of the serial line.
module tb_uart_tx_ctrl;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WIDTH-1:0] P_DATA;
  logic             Data_Valid;
  logic             PAR_EN;
  logic             parity_bit;
  logic             TX_OUT;
  logic             Busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Remaining line bits of the frame in flight, front = bit shown now.
  bit line_q[$];

  uart_tx_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .parity_bit(parity_bit),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  // Upstream even-parity calculator: registered, latches on every request.
  always @(posedge CLK or negedge RST) begin
    if (!RST) parity_bit <= 1'b0;
    else if (Data_Valid) parity_bit <= ^P_DATA;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge: check the current line, drive inputs, advance model.
  task automatic cycle(input bit dv, input logic [WIDTH-1:0] d, input bit pe);
    bit accept;
    chk("tx", TX_OUT, (line_q.size() > 0) ? line_q[0] : 1'b1);
    chk("busy", Busy, line_q.size() > 0);
    Data_Valid = dv;
    P_DATA     = d;
    PAR_EN     = pe;
    accept = dv && (line_q.size() <= 1);
    if (line_q.size() > 0) void'(line_q.pop_front());
    if (accept) begin
      line_q.push_back(1'b0);
      for (int i = 0; i < WIDTH; i++) line_q.push_back(d[i]);
      if (pe) line_q.push_back(^d);
      line_q.push_back(1'b1);
    end
    @(negedge CLK);
  endtask

  // Idle until the model frame drains, then check one idle cycle.
  task automatic drain();
    int n = 0;
    while (line_q.size() > 0 && n < 40) begin
      cycle(1'b0, WIDTH'($urandom), 1'($urandom));
      n++;
    end
    chk("drain_bound", line_q.size(), 0);
    cycle(1'b0, '0, 1'b0);
  endtask

  // Send one frame from idle and measure Busy length on the DUT.
  task automatic frame_len(input logic [WIDTH-1:0] d, input bit pe, input bit pe_mid, input int exp_len);
    int n = 0;
    cycle(1'b1, d, pe);
    while (Busy && n < 40) begin
      cycle(1'b0, '0, pe_mid);
      n++;
    end
    chk("frame_len", n, exp_len);
    drain();
  endtask

  initial begin
    RST = 1'b0; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0;
    @(negedge CLK);
    chk("rst_tx", TX_OUT, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // 0xA5 without parity: 10-cycle frame; 0x37 with parity: 11 cycles.
    frame_len(8'hA5, 1'b0, 1'b0, 10);
    frame_len(8'h37, 1'b1, 1'b1, 11);
    // PAR_EN dropped mid-frame must not remove the parity slot.
    frame_len(8'hC3, 1'b1, 1'b0, 11);

    // Back-to-back 0x00 then 0xFF, second request on the stop cycle.
    cycle(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b0);
    chk("b2b_stop_tx", TX_OUT, 1'b1);
    cycle(1'b1, 8'hFF, 1'b0);
    chk("b2b_start_tx", TX_OUT, 1'b0);
    chk("b2b_busy", Busy, 1'b1);
    drain();

    // Request during DATA of 0x5A is ignored.
    cycle(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 8'h13, 1'b1);
    drain();

    // Asynchronous reset mid-frame, then a clean 0x81 frame.
    cycle(1'b1, 8'hE7, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0);
    #2 RST = 1'b0;
    #1;
    chk("midrst_tx", TX_OUT, 1'b1);
    chk("midrst_busy", Busy, 1'b0);
    line_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    frame_len(8'h81, 1'b0, 1'b0, 10);

    // Random traffic, including requests that land mid-frame.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 5) == 0), WIDTH'($urandom), 1'($urandom));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
